// File: rtl/qtpa_pkg.sv
// Shared QTP pipeline types and widths.
package qtpa_pkg;

    localparam int unsigned DATA_WIDTH    = 16;
    localparam int unsigned REG_ADDR_W    = 4;
    localparam int unsigned NUM_ARCH_REGS = 16;

    typedef struct packed {
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/qtps_regfile.sv
// Register file: one synchronous write port, two asynchronous read ports with
// write-through bypass and optional hard-wired r0.
module qtps_regfile
    import qtpa_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_ARCH_REGS,
    parameter int unsigned R0_ZERO  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [REG_ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [REG_ADDR_W-1:0] i_rd1_addr,
    output logic [DATA_WIDTH-1:0] o_rd1_data,
    input  logic [REG_ADDR_W-1:0] i_rd2_addr,
    output logic [DATA_WIDTH-1:0] o_rd2_data
);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic w_wr_r0_drop;
    logic w_wr_ok;
    logic w_rd1_hit;
    logic w_rd2_hit;
    logic w_rd1_zero;
    logic w_rd2_zero;

    // A dropped r0 write neither lands in the array nor bypasses.
    assign w_wr_r0_drop = (R0_ZERO != 0) && (i_wr_addr == '0);
    assign w_wr_ok      = i_we && !rst && !w_wr_r0_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    assign w_rd1_hit  = w_wr_ok && (i_rd1_addr == i_wr_addr);
    assign w_rd2_hit  = w_wr_ok && (i_rd2_addr == i_wr_addr);
    assign w_rd1_zero = (R0_ZERO != 0) && (i_rd1_addr == '0);
    assign w_rd2_zero = (R0_ZERO != 0) && (i_rd2_addr == '0);

    assign o_rd1_data = w_rd1_hit  ? i_wr_data :
                        w_rd1_zero ? '0        : r_regs[i_rd1_addr];
    assign o_rd2_data = w_rd2_hit  ? i_wr_data :
                        w_rd2_zero ? '0        : r_regs[i_rd2_addr];

endmodule

// File: rtl/qtps_wb_stage.sv
// QTP-S writeback stage: commits results to the register file and flags,
// serves two bypassed read ports and counts retired writes.
module qtps_wb_stage
    import qtpa_pkg::*;
#(
    parameter int unsigned NUM_REGS  = NUM_ARCH_REGS,
    parameter int unsigned R0_ZERO   = 1,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wb_alu_result,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic                  wb_we,
    input  logic                  wb_flag_zero,
    input  logic                  wb_flag_carry,
    input  logic                  wb_flag_ovf,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0] rs2_data,
    output logic                  flag_zero,
    output logic                  flag_carry,
    output logic                  flag_ovf,
    output logic [CNT_WIDTH-1:0]  retire_count
);

    flags_t               w_flags_in;
    flags_t               r_flags;
    logic [CNT_WIDTH-1:0] r_retire_count;

    qtps_regfile #(
        .NUM_REGS (NUM_REGS),
        .R0_ZERO  (R0_ZERO)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_we       (wb_we),
        .i_wr_addr  (wb_rd_addr),
        .i_wr_data  (wb_alu_result),
        .i_rd1_addr (rs1_addr),
        .o_rd1_data (rs1_data),
        .i_rd2_addr (rs2_addr),
        .o_rd2_data (rs2_data)
    );

    assign w_flags_in = {wb_flag_zero, wb_flag_carry, wb_flag_ovf};

    // Flags and counter retire on every commit, r0 targets included.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags        <= '0;
            r_retire_count <= '0;
        end else if (wb_we) begin
            r_flags        <= w_flags_in;
            r_retire_count <= r_retire_count + CNT_WIDTH'(1);
        end
    end

    assign flag_zero    = r_flags.z;
    assign flag_carry   = r_flags.c;
    assign flag_ovf     = r_flags.v;
    assign retire_count = r_retire_count;

endmodule

// File: tb/tb_qtps_wb_stage.sv
// Scoreboard bench for qtps_wb_stage: a default instance and a narrow-counter,
// r0-as-ordinary-register instance driven with identical stimulus.
module tb_qtps_wb_stage;
    import qtpa_pkg::*;

    localparam int unsigned DW = DATA_WIDTH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          we  = 1'b0;
    logic [DW-1:0] data = '0;
    logic [3:0]    rd = '0, a1 = '0, a2 = '0;
    logic          fz = 1'b0, fc = 1'b0, fv = 1'b0;

    logic [DW-1:0] a_rs1, a_rs2, b_rs1, b_rs2;
    logic          a_fz, a_fc, a_fv, b_fz, b_fc, b_fv;
    logic [31:0]   a_cnt;
    logic [3:0]    b_cnt;

    qtps_wb_stage dut (
        .clk(clk), .rst(rst), .wb_alu_result(data), .wb_rd_addr(rd), .wb_we(we),
        .wb_flag_zero(fz), .wb_flag_carry(fc), .wb_flag_ovf(fv),
        .rs1_addr(a1), .rs1_data(a_rs1), .rs2_addr(a2), .rs2_data(a_rs2),
        .flag_zero(a_fz), .flag_carry(a_fc), .flag_ovf(a_fv), .retire_count(a_cnt)
    );

    qtps_wb_stage #(.R0_ZERO(0), .CNT_WIDTH(4)) dut_w (
        .clk(clk), .rst(rst), .wb_alu_result(data), .wb_rd_addr(rd), .wb_we(we),
        .wb_flag_zero(fz), .wb_flag_carry(fc), .wb_flag_ovf(fv),
        .rs1_addr(a1), .rs1_data(b_rs1), .rs2_addr(a2), .rs2_data(b_rs2),
        .flag_zero(b_fz), .flag_carry(b_fc), .flag_ovf(b_fv), .retire_count(b_cnt)
    );

    typedef struct {
        int            cyc;
        logic [DW-1:0] a_rs1, a_rs2, b_rs1, b_rs2;
        logic [2:0]    a_f, b_f;
        logic [31:0]   a_cnt;
        logic [3:0]    b_cnt;
    } exp_t;

    exp_t sb[$];

    // Reference state: plain arrays and integer counters.
    logic [DW-1:0]   ma [16];
    logic [DW-1:0]   mb [16];
    logic [2:0]      mfa = '0, mfb = '0;
    longint unsigned cnta = 0, cntb = 0;
    int              cyc_no = 0;

    int checks = 0;
    int errors = 0;

    function automatic logic [DW-1:0] model_read(input logic [DW-1:0] regs [16],
                                                 input bit r0z, input int addr);
        if (!rst && we && addr == int'(rd) && !(r0z && rd == 4'd0)) return data;
        if (r0z && addr == 0) return '0;
        return regs[addr];
    endfunction

    task automatic cycle(input bit r, input bit w, input logic [DW-1:0] d,
                         input logic [3:0] wr, input logic [2:0] f,
                         input logic [3:0] s1, input logic [3:0] s2);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; we = w; data = d; rd = wr; {fz, fc, fv} = f; a1 = s1; a2 = s2;
        e.cyc   = cyc_no;
        e.a_rs1 = model_read(ma, 1'b1, int'(s1));
        e.a_rs2 = model_read(ma, 1'b1, int'(s2));
        e.b_rs1 = model_read(mb, 1'b0, int'(s1));
        e.b_rs2 = model_read(mb, 1'b0, int'(s2));
        e.a_f   = mfa;
        e.b_f   = mfb;
        e.a_cnt = 32'(cnta);
        e.b_cnt = 4'(cntb);
        sb.push_back(e);
        cyc_no++;
        // Advance the model across the coming edge.
        if (r) begin
            for (int i = 0; i < 16; i++) begin
                ma[i] = '0;
                mb[i] = '0;
            end
            mfa = '0; mfb = '0; cnta = 0; cntb = 0;
        end else if (w) begin
            if (wr != 4'd0) ma[int'(wr)] = d;
            mb[int'(wr)] = d;
            mfa  = f;
            mfb  = f;
            cnta = (cnta + 1) % 64'h1_0000_0000;
            cntb = (cntb + 1) % 16;
        end
    endtask

    task automatic chk(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("a_rs1",   e.cyc, 32'(a_rs1), 32'(e.a_rs1));
                chk("a_rs2",   e.cyc, 32'(a_rs2), 32'(e.a_rs2));
                chk("a_flags", e.cyc, 32'({a_fz, a_fc, a_fv}), 32'(e.a_f));
                chk("a_count", e.cyc, a_cnt, e.a_cnt);
                chk("b_rs1",   e.cyc, 32'(b_rs1), 32'(e.b_rs1));
                chk("b_rs2",   e.cyc, 32'(b_rs2), 32'(e.b_rs2));
                chk("b_flags", e.cyc, 32'({b_fz, b_fc, b_fv}), 32'(e.b_f));
                chk("b_count", e.cyc, 32'(b_cnt), 32'(e.b_cnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout pending %0d expected 0", sb.size());
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] r_rd;
        for (int i = 0; i < 16; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
        cycle(1'b1, 1'b0, '0, 4'd0, 3'b000, 4'd0, 4'd0);
        cycle(1'b1, 1'b0, '0, 4'd0, 3'b000, 4'd1, 4'd2);

        // Reset discards state and the commit presented with it.
        cycle(1'b0, 1'b1, 16'h1234, 4'd5, 3'b101, 4'd5, 4'd0);
        cycle(1'b0, 1'b0, '0, 4'd0, 3'b000, 4'd5, 4'd5);
        cycle(1'b1, 1'b1, 16'hAAAA, 4'd6, 3'b111, 4'd5, 4'd6);
        cycle(1'b0, 1'b0, '0, 4'd0, 3'b000, 4'd5, 4'd6);

        // Commit then read back; flags and count one cycle later.
        cycle(1'b0, 1'b1, 16'hBEEF, 4'd3, 3'b010, 4'd1, 4'd2);
        cycle(1'b0, 1'b0, '0, 4'd0, 3'b000, 4'd3, 4'd3);

        // Same-cycle bypass on both ports.
        cycle(1'b0, 1'b1, 16'h00AA, 4'd7, 3'b000, 4'd7, 4'd7);

        // r0 write: dropped in the default instance, flags still update.
        cycle(1'b0, 1'b1, 16'hFFFF, 4'd0, 3'b100, 4'd0, 4'd0);
        cycle(1'b0, 1'b0, '0, 4'd0, 3'b000, 4'd0, 4'd7);

        // Bubble leaves everything alone.
        cycle(1'b0, 1'b1, 16'h4444, 4'd4, 3'b001, 4'd4, 4'd4);
        cycle(1'b0, 1'b0, 16'h5555, 4'd4, 3'b111, 4'd4, 4'd4);
        cycle(1'b0, 1'b0, '0, 4'd0, 3'b000, 4'd4, 4'd4);

        // Enough back-to-back commits to wrap the narrow counter.
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b1, 16'($urandom), 4'($urandom_range(1, 15)),
                  3'($urandom), 4'($urandom), 4'($urandom));
        end

        for (int i = 0; i < 400; i++) begin
            r_rd = 4'($urandom);
            cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                  16'($urandom), r_rd, 3'($urandom),
                  ($urandom_range(0, 2) == 0) ? r_rd : 4'($urandom),
                  ($urandom_range(0, 2) == 0) ? r_rd : 4'($urandom));
        end
        cycle(1'b0, 1'b0, '0, 4'd0, 3'b000, 4'd0, 4'd1);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
